// File: rtl/tb_lifo.sv
// rtl/tb_lifo.sv - ping-pong bit-order reversal buffer behind the Viterbi traceback
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   enable     synchronous run enable; low clears all state except bank data
//   wr_en      traceback write strobe; a run of consecutive highs is one block
//   d_in       decoded bit, valid with wr_en
//   out_ready  downstream accepts d_out this cycle
//   d_out      reordered decoded bit
//   d_valid    d_out valid
//   blk_last   last bit of a block, qualified by d_valid
//   overflow   sticky: at least one input bit was dropped
module tb_lifo #(
    parameter int DEPTH = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic wr_en,
    input  logic d_in,
    input  logic out_ready,
    output logic d_out,
    output logic d_valid,
    output logic blk_last,
    output logic overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    logic [DEPTH-1:0] bank_mem [2];
    logic [CW-1:0]    bank_len [2];
    logic [1:0]       bank_full;     // FULL covers both "waiting" and "draining"
    logic             wsel;
    logic             rsel;
    logic             wr_en_q;
    logic [CW-1:0]    wcount;
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    rptr_next;
    state_t           state;
    state_t           state_next;
    logic             wr_ok;
    logic             close_ok;
    logic             out_load;
    logic             bank_free;

    // Bank status is the pre-edge value, so a bank freed this edge is not writable yet.
    assign wr_ok    = enable && wr_en && !bank_full[wsel] && (wcount < CW'(DEPTH));
    // A block whose bits were all dropped leaves wcount at zero and is ignored.
    assign close_ok = enable && wr_en_q && !wr_en && (wcount != '0);

    always_comb begin
        state_next = state;
        rptr_next  = rptr;
        out_load   = 1'b0;
        bank_free  = 1'b0;
        case (state)
            IDLE: begin
                if (bank_full[rsel]) begin
                    rptr_next  = AW'(bank_len[rsel] - CW'(1));
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!d_valid || out_ready) begin
                    out_load = 1'b1;
                    if (rptr == '0) begin
                        bank_free  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        rptr_next = rptr - AW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            rptr  <= '0;
        end else if (!enable) begin
            state <= IDLE;
            rptr  <= '0;
        end else begin
            state <= state_next;
            rptr  <= rptr_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_full <= '0;
            wsel      <= 1'b0;
            rsel      <= 1'b0;
            wr_en_q   <= 1'b0;
            wcount    <= '0;
            overflow  <= 1'b0;
            d_out     <= 1'b0;
            d_valid   <= 1'b0;
            blk_last  <= 1'b0;
        end else if (!enable) begin
            bank_full <= '0;
            wsel      <= 1'b0;
            rsel      <= 1'b0;
            wr_en_q   <= 1'b0;
            wcount    <= '0;
            overflow  <= 1'b0;
            d_out     <= 1'b0;
            d_valid   <= 1'b0;
            blk_last  <= 1'b0;
        end else begin
            wr_en_q <= wr_en;

            if (wr_en) begin
                if (wr_ok) begin
                    wcount <= wcount + CW'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end

            // Reader and writer never own the same bank on one edge: a bank being
            // drained is FULL, so the writer cannot have collected bits into it.
            if (bank_free) begin
                bank_full[rsel] <= 1'b0;
                rsel            <= ~rsel;
            end
            if (close_ok) begin
                bank_full[wsel] <= 1'b1;
                wsel            <= ~wsel;
                wcount          <= '0;
            end

            if (out_load) begin
                d_out    <= bank_mem[rsel][rptr];
                d_valid  <= 1'b1;
                blk_last <= (rptr == '0);
            end else if (out_ready) begin
                d_valid  <= 1'b0;
                blk_last <= 1'b0;
            end
        end
    end

    // Bank contents and lengths carry no reset; they are only read while FULL.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            bank_mem[wsel][wcount[AW-1:0]] <= d_in;
        end
        if (close_ok) begin
            bank_len[wsel] <= wcount;
        end
    end

endmodule

// File: tb/tb_tb_lifo.sv
// tb/tb_tb_lifo.sv - self-checking bench for the tb_lifo reversal buffer
module tb_tb_lifo;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b1;
    logic wr_en = 1'b0;
    logic d_in = 1'b0;
    logic out_ready = 1'b0;
    logic d_out;
    logic d_valid;
    logic blk_last;
    logic overflow;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int first_valid = -1;
    int last_wr = 0;

    bit burst[$];
    bit got_d[$];
    bit got_last[$];
    bit exp_d[$];
    bit exp_l[$];

    tb_lifo #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .wr_en(wr_en),
        .d_in(d_in),
        .out_ready(out_ready),
        .d_out(d_out),
        .d_valid(d_valid),
        .blk_last(blk_last),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // One cycle: outputs seen at the negedge are those left by the previous edge;
    // the inputs set here are sampled on the next edge, together with a handshake.
    task automatic cycle(input logic wr, input logic din, input logic rdy, input logic en);
        @(negedge clk);
        cyc++;
        wr_en = wr;
        d_in = din;
        out_ready = rdy;
        enable = en;
        if (d_valid === 1'b1 && first_valid < 0) first_valid = cyc;
        if (en && rdy && d_valid === 1'b1) begin
            got_d.push_back(d_out);
            got_last.push_back(blk_last);
        end
    endtask

    task automatic clear_obs;
        got_d.delete();
        got_last.delete();
        exp_d.delete();
        exp_l.delete();
        first_valid = -1;
    endtask

    task automatic rand_burst(input int n);
        burst.delete();
        repeat (n) burst.push_back(1'($urandom));
    endtask

    // Reference: a block leaves as its first DEPTH bits in reverse, last flag on the final one.
    task automatic model_burst;
        int n;
        n = (burst.size() > DEPTH) ? DEPTH : burst.size();
        for (int i = n - 1; i >= 0; i--) begin
            exp_d.push_back(burst[i]);
            exp_l.push_back(i == 0);
        end
    endtask

    task automatic send_burst(input int gap);
        foreach (burst[i]) begin
            cycle(1'b1, burst[i], 1'b1, 1'b1);
            last_wr = cyc;
        end
        model_burst();
        repeat (gap) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic drain(input int max);
        int k;
        k = 0;
        while (k < max && got_d.size() < exp_d.size()) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1);
            k++;
        end
        repeat (6) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({d_out, d_valid, blk_last, overflow} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold: got %b, want 0000", {d_out, d_valid, blk_last, overflow});
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1);
            n_checks++;
            if ({d_out, d_valid, blk_last, overflow} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_idle%0d: got %b, want 0000", i, {d_out, d_valid, blk_last, overflow});
            end
        end
    endtask

    task automatic test_single_block;
        clear_obs();
        burst = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        send_burst(1);
        drain(40);
        n_checks++;
        if (got_d.size() !== exp_d.size()) begin
            n_fail++;
            $display("FAIL single_count: got %0d bits, want %0d", got_d.size(), exp_d.size());
        end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL single_bit%0d: got d=%0b last=%0b, want d=%0b last=%0b",
                         i, got_d[i], got_last[i], exp_d[i], exp_l[i]);
            end
        end
        // Last write on edge E0, first bit loaded on E3, seen at the following negedge.
        n_checks++;
        if (first_valid !== last_wr + 4) begin
            n_fail++;
            $display("FAIL single_latency: first valid at cycle %0d, want %0d", first_valid, last_wr + 4);
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL single_overflow: got %b, want 0", overflow);
        end
    endtask

    task automatic test_ping_pong;
        int pulses;
        clear_obs();
        rand_burst(DEPTH);
        send_burst(1);
        rand_burst(DEPTH);
        send_burst(1);
        drain(400);
        n_checks++;
        if (got_d.size() !== exp_d.size()) begin
            n_fail++;
            $display("FAIL pp_count: got %0d bits, want %0d", got_d.size(), exp_d.size());
        end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL pp_bit%0d: got d=%0b last=%0b, want d=%0b last=%0b",
                         i, got_d[i], got_last[i], exp_d[i], exp_l[i]);
            end
        end
        pulses = 0;
        foreach (got_last[i]) pulses += int'(got_last[i]);
        n_checks++;
        if (pulses !== 2) begin
            n_fail++;
            $display("FAIL pp_last_pulses: got %0d, want 2", pulses);
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL pp_overflow: got %b, want 0", overflow);
        end
    endtask

    task automatic test_backpressure;
        logic pd;
        logic pl;
        logic rdy;
        bit stall;
        clear_obs();
        rand_burst(16);
        model_burst();
        stall = 1'b0;
        pd = 1'b0;
        pl = 1'b0;
        for (int i = 0; i < 150; i++) begin
            rdy = (i % 3 == 0);
            cycle(i < 16, (i < 16) ? burst[i] : 1'b0, rdy, 1'b1);
            if (stall) begin
                n_checks++;
                if (d_valid !== 1'b1 || d_out !== pd || blk_last !== pl) begin
                    n_fail++;
                    $display("FAIL bp_stable_cyc%0d: got v=%b d=%b last=%b, want v=1 d=%b last=%b",
                             i, d_valid, d_out, blk_last, pd, pl);
                end
            end
            stall = (d_valid === 1'b1) && !rdy;
            pd = d_out;
            pl = blk_last;
        end
        n_checks++;
        if (got_d.size() !== exp_d.size()) begin
            n_fail++;
            $display("FAIL bp_count: got %0d bits, want %0d", got_d.size(), exp_d.size());
        end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL bp_bit%0d: got d=%0b last=%0b, want d=%0b last=%0b",
                         i, got_d[i], got_last[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_overflow;
        clear_obs();
        rand_burst(DEPTH + 3);
        model_burst();
        for (int i = 0; i <= DEPTH + 3; i++) begin
            if (i < DEPTH + 3) cycle(1'b1, burst[i], 1'b1, 1'b1);
            else cycle(1'b0, 1'b0, 1'b1, 1'b1);
            // Here overflow reflects the write of bit i-1; bit DEPTH is the first dropped.
            n_checks++;
            if (overflow !== logic'(i >= DEPTH + 1)) begin
                n_fail++;
                $display("FAIL ovf_flag%0d: got %b, want %b", i, overflow, i >= DEPTH + 1);
            end
        end
        drain(200);
        n_checks++;
        if (got_d.size() !== exp_d.size()) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d bits, want %0d", got_d.size(), exp_d.size());
        end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL ovf_bit%0d: got d=%0b last=%0b, want d=%0b last=%0b",
                         i, got_d[i], got_last[i], exp_d[i], exp_l[i]);
            end
        end
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b, want 1", overflow);
        end
    endtask

    task automatic test_abort(input bit use_rst);
        int k;
        string tag;
        tag = use_rst ? "abort_rst" : "abort_en";
        clear_obs();
        rand_burst(DEPTH + 2);
        send_burst(0);
        k = 0;
        while (got_d.size() < 5 && k < 200) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1);
            k++;
        end
        n_checks++;
        if (d_valid !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_pre: got v=%b ovf=%b, want v=1 ovf=1", tag, d_valid, overflow);
        end
        if (use_rst) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            n_checks++;
            if (d_valid !== 1'b0 || overflow !== 1'b0 || blk_last !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_clear: got v=%b ovf=%b last=%b, want 0 0 0", tag, d_valid, overflow, blk_last);
            end
            #1;
            rst = 1'b1;
        end else begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            cycle(1'b0, 1'b0, 1'b1, 1'b1);
            n_checks++;
            if (d_valid !== 1'b0 || overflow !== 1'b0 || blk_last !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_clear: got v=%b ovf=%b last=%b, want 0 0 0", tag, d_valid, overflow, blk_last);
            end
        end
        clear_obs();
        burst = {1'b1, 1'b1, 1'b0, 1'b1};
        send_burst(1);
        drain(40);
        n_checks++;
        if (got_d.size() !== 4) begin
            n_fail++;
            $display("FAIL %s_count: got %0d bits, want 4", tag, got_d.size());
        end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL %s_bit%0d: got d=%0b last=%0b, want d=%0b last=%0b",
                         tag, i, got_d[i], got_last[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_ping_pong();
        test_backpressure();
        test_overflow();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tb_lifo.md
# tb_lifo

Bit-order reversal buffer that sits directly downstream of the Viterbi traceback unit. Traceback emits each decoded block last-bit-first, as a burst of `d_in` bits qualified by `wr_en`. This block stores each burst in one of two ping-pong banks. It then replays the burst in reverse order, so decoded bits leave in original transmit order through a valid/ready stream with an end-of-block marker.

## Interface
- `DEPTH`, 64: maximum bits per block and per bank; power of two, ≥4.
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  synchronous run enable; low clears all state (same values as reset).
- `wr_en`  in  1  write strobe from traceback; a run of consecutive highs is one block.
- `d_in`  in  1  decoded bit from traceback, valid when `wr_en`=1.
- `out_ready`  in  1  downstream accepts `d_out` this cycle.
- `d_out`  out  1  reordered decoded bit.
- `d_valid`  out  1  `d_out` valid.
- `blk_last`  out  1  marks the final bit of a block; qualified by `d_valid`.
- `overflow`  out  1  sticky flag: at least one input bit was dropped.

## Operation
- Storage:
  - Two banks of DEPTH bits: `bank[0]` and `bank[1]`.
  - Per bank: status (EMPTY, FULL) and a length counter of width clog2(DEPTH+1).
  - Write select `wsel` and read select `rsel`; both reset to 0.
- Write side:
  - A write occurs on a cycle with `enable`=1 and `wr_en`=1.
  - If `bank[wsel]` is EMPTY and wcount<DEPTH: store `d_in` at address wcount, then increment wcount.
  - Otherwise drop the bit and set `overflow`.
  - Bank status is taken before the clock edge. A bank freed by the reader on the same edge is not writable that cycle.
- Block close:
  - `wr_en_q` is `wr_en` registered.
  - A close occurs when `wr_en_q`=1 and `wr_en`=0.
  - If wcount>0 on close: mark `bank[wsel]` FULL, latch length=wcount, toggle `wsel`, clear wcount.
  - If wcount=0 (all bits dropped): ignore the close; no toggle.
- Read FSM, two states:
  - IDLE: if `bank[rsel]` is FULL, load rptr=length-1 and go to DRAIN.
  - DRAIN: when the output stage can load (`d_valid`=0 or `out_ready`=1):
    - load `d_out`=`bank[rsel][rptr]`, `d_valid`=1, `blk_last`=(rptr==0).
    - if rptr==0: mark `bank[rsel]` EMPTY, toggle `rsel`, go to IDLE.
    - otherwise decrement rptr.
- Output stage:
  - Registered.
  - Holds `d_out`, `blk_last` and `d_valid` stable while `d_valid`=1 and `out_ready`=0.
  - Drops `d_valid` after acceptance if no new bit is loaded.
- `overflow`: sticky; cleared only by `rst` or `enable`=0.
- `enable`=0:
  - Clear on the next edge: both banks EMPTY, wcount, rptr, `wsel`, `rsel`, `wr_en_q` to 0, FSM to IDLE, outputs to 0.
  - Bank data contents are not cleared.

## Timing
- Reset values: `d_out`=0, `d_valid`=0, `blk_last`=0, `overflow`=0; FSM IDLE; all banks EMPTY.
- `rst` asserted mid-operation clears state immediately. An in-flight block is lost without `blk_last`.
- Latency, with the last write sampled at edge E0:
  - close registers at E1;
  - FSM enters DRAIN at E2;
  - first `d_valid`=1 after E3, i.e. 3 cycles after the last `wr_en`-high cycle.
- Throughput:
  - 1 bit/cycle while `out_ready`=1.
  - One IDLE bubble cycle between consecutive blocks.
- Gap rule: a new burst may start on the cycle directly after a close. It fills the other bank.
- Both banks FULL or draining: writes are dropped with `overflow`=1. Nothing is stalled upstream.
- Wrap-around: wcount saturates at DEPTH; `wsel` and `rsel` are 1-bit toggles.

## Test plan
- Reset/idle: hold `rst`=0, then release with `wr_en`=0 for 20 cycles -> `d_out`, `d_valid`, `blk_last`, `overflow` remain 0.
- Single block: burst `d_in`=1,0,1,1,0,0,1,0 with `out_ready`=1 -> output 0,1,0,0,1,1,0,1; first `d_valid` 3 cycles after the last write; `blk_last`=1 only with the 8th bit; `overflow`=0.
- Ping-pong: two DEPTH-bit bursts (random) separated by 1 idle cycle, `out_ready`=1 -> each block is output reversed and in order; no `overflow`; exactly 2 `blk_last` pulses.
- Backpressure: 16-bit block with `out_ready` toggling 1,0,0,1,... -> `d_out`/`blk_last` stable during stalls; all 16 bits delivered reversed, none duplicated.
- Overflow: single burst of DEPTH+3 bits -> `overflow`=1 from the first dropped bit; output is the first DEPTH bits reversed; `blk_last` on the DEPTH-th output bit.
- Abort:
  - drop `enable` for 1 cycle in mid-drain -> `d_valid`=0 on the next edge, `overflow` cleared; a following 4-bit block 1,1,0,1 outputs 1,0,1,1.
  - repeat using `rst` pulse -> same result.
